// File: rtl/bus_transfer_ctrl_pkg.sv
// Shared definitions for the register-bus writer: state encoding, op codes, default width.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_bus_pkg;

  localparam int DEF_WIDTH = 8;

  // State encoding, kept as named constants so other blocks can decode the state value.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRIVE = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_CLR   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    DRIVE = ST_DRIVE,
    LOAD  = ST_LOAD,
    CLR   = ST_CLR,
    DONE  = ST_DONE
  } state_e;

  // Operation codes carried on op.
  localparam logic OP_XFER = 1'b0;
  localparam logic OP_CLR  = 1'b1;

endpackage

// File: rtl/bus_transfer_ctrl_if.sv
// Sequencer <-> bus writer signal bundle: request side, bus drive, register strobes.
// Latency: none (wiring only).
// Backpressure: req/ack handshake; requests arriving while busy are dropped by the writer.
interface bus_transfer_ctrl_if
  import cpu_bus_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_SRC = 4,
  parameter int NUM_DST = 4,
  parameter int SEL_W   = 2
) ();

  logic                     req;
  logic                     op;
  logic [SEL_W-1:0]         src_sel;
  logic [SEL_W-1:0]         dst_sel;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       bus_oe;
  logic [WIDTH-1:0]         bus_out;
  logic [NUM_DST-1:0]       dst_load;
  logic [NUM_DST-1:0]       dst_clear;
  logic                     busy;
  logic                     ack;
  logic                     err;
  logic [7:0]               xfer_count;

  // Sequencer / testbench side.
  modport master (
    output req, op, src_sel, dst_sel, src_data,
    input  bus_oe, bus_out, dst_load, dst_clear, busy, ack, err, xfer_count
  );

  // Bus writer side.
  modport slave (
    input  req, op, src_sel, dst_sel, src_data,
    output bus_oe, bus_out, dst_load, dst_clear, busy, ack, err, xfer_count
  );

endinterface

// File: rtl/bus_transfer_ctrl_onehot_dec.sv
// Binary select to one-hot decoder with enable; out-of-range selects give all zeros.
// Latency: combinational.
// Backpressure: none.
module onehot_dec #(
  parameter int SEL_W = 2,
  parameter int N     = 4
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     oh
);

  // At most one bit can match, so the output is one-hot or zero by construction.
  always_comb begin
    oh = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (sel == SEL_W'(i))) oh[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Bus writer: moves one source onto the shared bus and strobes one register's load or clear.
// Latency: req sample -> ack is 3 cycles (transfer), 2 (clear), 1 (selector error).
// Backpressure: req is only sampled in IDLE; requests while busy are dropped, not queued.
module bus_transfer_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_SRC = 4,
  parameter int NUM_DST = 4,
  parameter int SEL_W   = 2
) (
  input  logic                clk,
  input  logic                clear_n,
  bus_transfer_ctrl_if.slave  bif
);

  localparam logic [SEL_W:0] NSRC = (SEL_W+1)'(NUM_SRC);
  localparam logic [SEL_W:0] NDST = (SEL_W+1)'(NUM_DST);

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic [SEL_W-1:0] dst_q, dst_d;
  logic             range_bad;

  logic [NUM_SRC-1:0] bus_oe_q, bus_oe_d;
  logic [WIDTH-1:0]   bus_out_q, bus_out_d;
  logic [NUM_DST-1:0] dst_load_q, dst_load_d;
  logic [NUM_DST-1:0] dst_clear_q, dst_clear_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [7:0]         count_q, count_d;

  logic [WIDTH-1:0]   src_word;
  logic               oe_en, load_en, clr_en;

  // State and latched operands; reset returns to IDLE at once, even mid-operation.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      op_q    <= OP_XFER;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  // Next state and operand capture; the source range only matters for transfers.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_d     = src_q;
    dst_d     = dst_q;
    range_bad = 1'b0;
    case (state_q)
      IDLE: begin
        if (bif.req) begin
          op_d      = bif.op;
          src_d     = bif.src_sel;
          dst_d     = bif.dst_sel;
          range_bad = ({1'b0, bif.dst_sel} >= NDST) ||
                      ((bif.op == OP_XFER) && ({1'b0, bif.src_sel} >= NSRC));
          if (range_bad)             state_d = DONE;
          else if (bif.op == OP_CLR) state_d = CLR;
          else                       state_d = DRIVE;
        end
      end
      DRIVE:   state_d = LOAD;
      LOAD:    state_d = DONE;
      CLR:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe enables are derived from the state being entered so the registered
  // outputs line up with that state's cycle.
  assign oe_en   = (state_d == DRIVE) || (state_d == LOAD);
  assign load_en = (state_d == LOAD);
  assign clr_en  = (state_d == CLR);

  onehot_dec #(.SEL_W(SEL_W), .N(NUM_SRC)) u_dec_oe (
    .en  (oe_en),
    .sel (src_d),
    .oh  (bus_oe_d)
  );

  onehot_dec #(.SEL_W(SEL_W), .N(NUM_DST)) u_dec_load (
    .en  (load_en),
    .sel (dst_d),
    .oh  (dst_load_d)
  );

  onehot_dec #(.SEL_W(SEL_W), .N(NUM_DST)) u_dec_clear (
    .en  (clr_en),
    .sel (dst_d),
    .oh  (dst_clear_d)
  );

  // Source mux for the latched source index.
  always_comb begin
    src_word = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_q == SEL_W'(i)) src_word = bif.src_data[i*WIDTH +: WIDTH];
    end
  end

  // Bus value is captured on the edge ending DRIVE and held only through LOAD,
  // so source changes during LOAD never reach the destination.
  always_comb begin
    bus_out_d = load_en ? src_word : '0;
    busy_d    = (state_d != IDLE);
    ack_d     = (state_d == DONE);
    err_d     = range_bad;
    count_d   = ((state_d == DONE) && (state_q != DONE) && !range_bad) ? count_q + 8'd1
                                                                        : count_q;
  end

  // Output registers; all cleared asynchronously so no strobe survives reset.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      bus_oe_q    <= '0;
      bus_out_q   <= '0;
      dst_load_q  <= '0;
      dst_clear_q <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      bus_oe_q    <= bus_oe_d;
      bus_out_q   <= bus_out_d;
      dst_load_q  <= dst_load_d;
      dst_clear_q <= dst_clear_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  assign bif.bus_oe     = bus_oe_q;
  assign bif.bus_out    = bus_out_q;
  assign bif.dst_load   = dst_load_q;
  assign bif.dst_clear  = dst_clear_q;
  assign bif.busy       = busy_q;
  assign bif.ack        = ack_q;
  assign bif.err        = err_q;
  assign bif.xfer_count = count_q;

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Directed bench for the register-bus writer with a small register-file model on the strobes.
// Latency: checks sampled 1ns after each rising edge.
// Backpressure: every wait for ack is bounded.
module tb_bus_transfer_ctrl;
  import cpu_bus_pkg::*;

  localparam int W  = 8;
  localparam int NS = 3;
  localparam int ND = 3;
  localparam int SW = 2;

  logic clk     = 1'b0;
  logic clear_n = 1'b0;

  always #5 clk = ~clk;

  bus_transfer_ctrl_if #(.WIDTH(W), .NUM_SRC(NS), .NUM_DST(ND), .SEL_W(SW)) bif ();

  bus_transfer_ctrl #(.WIDTH(W), .NUM_SRC(NS), .NUM_DST(ND), .SEL_W(SW)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bif     (bif)
  );

  // Destination registers as they would sit on the bus.
  logic [7:0] regs [ND];
  always @(posedge clk) begin
    for (int i = 0; i < ND; i++) begin
      if (bif.dst_load[i])       regs[i] <= bif.bus_out;
      else if (bif.dst_clear[i]) regs[i] <= '0;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [7:0] v);
    bif.src_data[i*W +: W] = v;
  endtask

  task automatic start(input logic op, input logic [1:0] s, input logic [1:0] d);
    bif.req     = 1'b1;
    bif.op      = op;
    bif.src_sel = s;
    bif.dst_sel = d;
  endtask

  // One full operation from IDLE; leaves the DUT back in IDLE.
  task automatic do_xfer(input logic op, input logic [1:0] s, input logic [1:0] d, output bit ok);
    start(op, s, d);
    tick();
    bif.req = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin
      if (bif.ack) ok = 1'b1;
      else tick();
    end
    if (ok) tick();
  endtask

  initial begin
    bit ok;
    bit all_ok;
    int a1, a2, nack, loadcyc;
    logic [ND-1:0] load_or;

    bif.req      = 1'b0;
    bif.op       = OP_XFER;
    bif.src_sel  = '0;
    bif.dst_sel  = '0;
    bif.src_data = '0;

    // Reset state
    tick(); tick();
    chk("rst_busy",  bif.busy, 0);
    chk("rst_ack",   bif.ack, 0);
    chk("rst_err",   bif.err, 0);
    chk("rst_oe",    bif.bus_oe, 0);
    chk("rst_load",  bif.dst_load, 0);
    chk("rst_clear", bif.dst_clear, 0);
    chk("rst_bus",   bif.bus_out, 0);
    chk("rst_count", bif.xfer_count, 0);
    clear_n = 1'b1;
    tick();
    chk("idle_busy", bif.busy, 0);

    // Transfer src1 (A5) -> dst2
    set_src(1, 8'hA5);
    start(OP_XFER, 2'd1, 2'd2);
    tick();
    bif.req = 1'b0;
    chk("x1_oe",   bif.bus_oe, 3'b010);
    chk("x1_load", bif.dst_load, 0);
    chk("x1_busy", bif.busy, 1);
    chk("x1_ack",  bif.ack, 0);
    tick();
    set_src(1, 8'h5A);
    chk("x2_oe",    bif.bus_oe, 3'b010);
    chk("x2_load",  bif.dst_load, 3'b100);
    chk("x2_bus",   bif.bus_out, 8'hA5);
    chk("x2_clear", bif.dst_clear, 0);
    tick();
    chk("x3_ack",   bif.ack, 1);
    chk("x3_err",   bif.err, 0);
    chk("x3_count", bif.xfer_count, 1);
    chk("x3_load",  bif.dst_load, 0);
    chk("x3_oe",    bif.bus_oe, 0);
    chk("x3_bus",   bif.bus_out, 0);
    chk("x3_reg2",  regs[2], 8'hA5);
    tick();
    chk("x4_busy", bif.busy, 0);
    chk("x4_ack",  bif.ack, 0);

    // Clear dst2; out-of-range src is irrelevant for a clear
    start(OP_CLR, 2'd3, 2'd2);
    tick();
    bif.req = 1'b0;
    chk("c1_clear", bif.dst_clear, 3'b100);
    chk("c1_oe",    bif.bus_oe, 0);
    chk("c1_bus",   bif.bus_out, 0);
    chk("c1_load",  bif.dst_load, 0);
    chk("c1_ack",   bif.ack, 0);
    tick();
    chk("c2_ack",   bif.ack, 1);
    chk("c2_err",   bif.err, 0);
    chk("c2_clear", bif.dst_clear, 0);
    chk("c2_count", bif.xfer_count, 2);
    chk("c2_reg2",  regs[2], 0);
    tick();

    // Request during DRIVE is dropped
    set_src(2, 8'h77);
    start(OP_XFER, 2'd2, 2'd0);
    tick();
    start(OP_XFER, 2'd0, 2'd1);
    tick();
    bif.req = 1'b0;
    nack = 0; loadcyc = 0; load_or = '0;
    for (int c = 0; c < 8; c++) begin
      if (bif.ack) nack++;
      if (bif.dst_load != 0) loadcyc++;
      load_or = load_or | bif.dst_load;
      tick();
    end
    chk("bi_acks",   nack, 1);
    chk("bi_loads",  loadcyc, 1);
    chk("bi_ldmask", load_or, 3'b001);
    chk("bi_reg0",   regs[0], 8'h77);
    chk("bi_count",  bif.xfer_count, 3);

    // Back-to-back with req held high
    set_src(0, 8'h3C);
    set_src(1, 8'hFF);
    start(OP_XFER, 2'd0, 2'd0);
    a1 = -1; a2 = -1; nack = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bif.ack) begin
        if (nack == 0) a1 = c;
        else a2 = c;
        nack++;
      end
      if (c == 1) begin
        bif.src_sel = 2'd1;
        bif.dst_sel = 2'd1;
      end
      if (c == 5) bif.req = 1'b0;
    end
    chk("bb_ack1",  a1, 3);
    chk("bb_ack2",  a2, 7);
    chk("bb_nack",  nack, 2);
    chk("bb_reg0",  regs[0], 8'h3C);
    chk("bb_reg1",  regs[1], 8'hFF);
    chk("bb_count", bif.xfer_count, 5);

    // Destination out of range
    start(OP_XFER, 2'd0, 2'd3);
    tick();
    bif.req = 1'b0;
    chk("ed_ack",   bif.ack, 1);
    chk("ed_err",   bif.err, 1);
    chk("ed_load",  bif.dst_load, 0);
    chk("ed_oe",    bif.bus_oe, 0);
    chk("ed_clear", bif.dst_clear, 0);
    chk("ed_count", bif.xfer_count, 5);
    tick();
    chk("ed2_ack",  bif.ack, 0);
    chk("ed2_err",  bif.err, 0);
    chk("ed2_busy", bif.busy, 0);

    // Source out of range on a transfer
    start(OP_XFER, 2'd3, 2'd0);
    tick();
    bif.req = 1'b0;
    chk("es_ack",   bif.ack, 1);
    chk("es_err",   bif.err, 1);
    chk("es_oe",    bif.bus_oe, 0);
    chk("es_count", bif.xfer_count, 5);
    tick();

    // Counter wrap
    all_ok = 1'b1;
    for (int n = 0; n < 250; n++) begin
      do_xfer(OP_XFER, 2'd0, 2'd0, ok);
      all_ok = all_ok & ok;
    end
    chk("wr_acks",  all_ok, 1);
    chk("wr_255",   bif.xfer_count, 8'hFF);
    do_xfer(OP_XFER, 2'd0, 2'd0, ok);
    chk("wr_ok",    ok, 1);
    chk("wr_00",    bif.xfer_count, 8'h00);
    do_xfer(OP_XFER, 2'd0, 2'd0, ok);
    chk("wr_01",    bif.xfer_count, 8'h01);

    // Reset asserted during LOAD
    set_src(1, 8'h99);
    start(OP_XFER, 2'd1, 2'd1);
    tick();
    bif.req = 1'b0;
    tick();
    chk("rl_pre_load", bif.dst_load, 3'b010);
    #1 clear_n = 1'b0;
    #1;
    chk("rl_load",  bif.dst_load, 0);
    chk("rl_oe",    bif.bus_oe, 0);
    chk("rl_bus",   bif.bus_out, 0);
    chk("rl_busy",  bif.busy, 0);
    chk("rl_ack",   bif.ack, 0);
    chk("rl_count", bif.xfer_count, 0);
    tick();
    chk("rl_reg1",  regs[1], 8'hFF);
    clear_n = 1'b1;
    tick();
    chk("rl_idle",  bif.busy, 0);
    do_xfer(OP_CLR, 2'd0, 2'd1, ok);
    chk("rl_resume", ok, 1);
    chk("rl_count1", bif.xfer_count, 1);
    chk("rl_reg1c",  regs[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
